matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Upstream stage of the 4x4 determinant unit.
- Accepts matrix elements byte-serially over a valid/ready stream, in row-major order.
- Assembles them into the 128-bit packed matrix word that the determinant unit consumes. Element (r,c) sits at bits [127-8*(4r+c) -: 8].
- Supports 2x2 and 3x3 loads by embedding the NxN matrix top-left and padding with identity, so the 4x4 determinant equals the NxN determinant.

Parameters:
- ELEM_W, 8, element width in bits (signed two's complement). The packed output is 16*ELEM_W bits wide.
- MAX_DIM, 4, maximum matrix dimension. Fixed at 4; this is the packing geometry.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a new load; sampled in IDLE only
- size  in  2  dimension, latched on an accepted start: 2'd2 = 2x2, 2'd3 = 3x3, any other value = 4x4
- in_valid  in  1  in_data holds a valid element
- in_data  in  ELEM_W  matrix element, row-major
- in_ready  out  1  loader accepts an element this cycle
- mat_out  out  16*ELEM_W  packed matrix to the determinant unit
- mat_valid  out  1  mat_out holds a complete matrix
- mat_ready  in  1  consumer takes mat_out
- busy  out  1  high in LOAD or HOLD
- start_err  out  1  one-cycle pulse when start is asserted outside IDLE

Behaviour:
- Reset (async assert, sync release): state = IDLE, mat_out = 0, mat_valid = 0, in_ready = 0, busy = 0, start_err = 0, row/col counters = 0, latched N = 4.
- FSM states:
  - IDLE: in_ready = 0. When start = 1:
    - latch N from size;
    - load mat_out with the identity-padded zero image: every diagonal element (k,k) with k >= N = 8'h01, all other elements = 0;
    - set row = col = 0;
    - go to LOAD.
  - LOAD: in_ready = 1 (combinational from state). A beat is accepted when in_valid & in_ready.
    - On an accepted beat, write in_data to element (row,col).
    - If col == N-1: col = 0, row++. Otherwise col++.
    - On the beat with row == N-1 and col == N-1, go to HOLD.
    - in_valid low cycles simply stall; no timeout.
  - HOLD: in_ready = 0, mat_valid = 1, mat_out stable.
    - If mat_ready = 1, go to IDLE; mat_valid falls the next cycle.
    - mat_valid stays high indefinitely without mat_ready.
- Latency:
  - start to first possible beat: 1 cycle.
  - mat_valid rises the cycle after the N*N-th accepted beat.
  - Minimum start-to-mat_valid: N*N + 1 cycles.
- mat_out retains the last matrix in IDLE after handoff, until the next accepted start overwrites it.
- busy = (state != IDLE), registered with the state.
- start in LOAD or HOLD: ignored (no restart, no change to N), and start_err pulses for exactly one cycle per asserted cycle.
- start and mat_ready in the same HOLD cycle: handoff completes, state goes to IDLE, start is ignored and start_err pulses. A new start is required in IDLE.
- Element values pass through unchanged, with no sign extension or saturation.
- Writes never touch padded positions: the counters wrap at N, not at 4.
- rst_n asserted mid-LOAD or mid-HOLD: immediate return to the reset values. The partial matrix is discarded and mat_out = 0.

Test Plan:
- 4x4 (size = 0), start, then beats 8'h01..8'h10 back-to-back → in_ready high for 16 cycles. mat_valid = 1 one cycle after beat 16, with mat_out = 128'h0102030405060708090A0B0C0D0E0F10. mat_ready = 1 → mat_valid = 0 next cycle, busy = 0.
- 2x2 (size = 2), beats 3, 8'hFE, 5, 7 → mat_out = 128'h03FE0000_05070000_00000100_00000001. The downstream determinant reads 8'h1F (31).
- 3x3 (size = 3), beats 1..9 with in_valid deasserted for 2 cycles after beats 2 and 6 → only valid beats are accepted. mat_valid rises 14 cycles after the first beat (9 accepted + 4 idle + 1). Element (3,3) = 8'h01; row 3 and column 3 are otherwise 0.
- HOLD with mat_ready = 0 for 20 cycles → mat_valid and mat_out stable, in_ready = 0. Extra in_valid beats are not accepted. start in cycle 5 → start_err pulse of one cycle, no state change.
- rst_n low after the 7th beat of a 4x4 load → all outputs return to reset values asynchronously. A subsequent fresh 4x4 load of all 8'h80 → mat_out = {16{8'h80}}.
- start and mat_ready together in HOLD → IDLE next cycle, start_err = 1 for one cycle, busy = 0. mat_out still holds the previous matrix.

Source files
------------

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// matrix_loader : byte-serial row-major loader producing the packed 4x4
//                 matrix word (2x2/3x3 embedded top-left, identity-padded)
// Revision 1.0
// ============================================================================
module matrix_loader #(
   parameter int ELEM_W  = 8,
   parameter int MAX_DIM = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [1:0]                          size,
   input  logic                                in_valid,
   input  logic [ELEM_W-1:0]                   in_data,
   output logic                                in_ready,
   output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   mat_out,
   output logic                                mat_valid,
   input  logic                                mat_ready,
   output logic                                busy,
   output logic                                start_err
);

   localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [MAT_W-1:0] mat_q, mat_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [2:0]       n_q, n_d;
   logic             busy_q, busy_d;
   logic             start_err_q, start_err_d;

   logic             last_col;
   logic             last_row;
   logic [3:0]       elem_idx;

   assign last_col = ({1'b0, col_q} == (n_q - 3'd1));
   assign last_row = ({1'b0, row_q} == (n_q - 3'd1));
   // Linear element index 4*row+col; the packing geometry is fixed at 4x4.
   assign elem_idx = {row_q, col_q};

   always_comb begin
      state_d     = state_q;
      mat_d       = mat_q;
      row_d       = row_q;
      col_d       = col_q;
      n_d         = n_q;
      start_err_d = start && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (size)
                  2'd2:    n_d = 3'd2;
                  2'd3:    n_d = 3'd3;
                  default: n_d = 3'd4;
               endcase
               // Identity on the padded diagonal keeps det(4x4) == det(NxN).
               mat_d = '0;
               for (int k = 0; k < MAX_DIM; k++) begin
                  if (k >= int'(n_d)) begin
                     mat_d[MAT_W-1-ELEM_W*(MAX_DIM*k+k) -: ELEM_W] = ELEM_W'(1);
                  end
               end
               row_d   = 2'd0;
               col_d   = 2'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               mat_d[MAT_W-1-ELEM_W*int'(elem_idx) -: ELEM_W] = in_data;
               if (last_col) begin
                  col_d = 2'd0;
                  row_d = row_q + 2'd1;
                  if (last_row) begin
                     state_d = S_HOLD;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         S_HOLD: begin
            if (mat_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mat_q       <= '0;
         row_q       <= 2'd0;
         col_q       <= 2'd0;
         n_q         <= 3'd4;
         busy_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mat_q       <= mat_d;
         row_q       <= row_d;
         col_q       <= col_d;
         n_q         <= n_d;
         busy_q      <= busy_d;
         start_err_q <= start_err_d;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign mat_valid = (state_q == S_HOLD);
   assign mat_out   = mat_q;
   assign busy      = busy_q;
   assign start_err = start_err_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// ============================================================================
// tb_matrix_loader : scoreboard bench for matrix_loader
// Revision 1.0
// ============================================================================
module tb_matrix_loader;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   size = 2'd0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_ready;
   logic [127:0] mat_out;
   logic         mat_valid;
   logic         mat_ready = 1'b0;
   logic         busy;
   logic         start_err;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   logic [127:0] sb[$];
   logic [7:0]   elems[16];
   int           gaps[16];
   logic [127:0] last_exp;

   matrix_loader #(.ELEM_W(8), .MAX_DIM(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .size      (size),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mat_out   (mat_out),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .busy      (busy),
      .start_err (start_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int dim_of(input logic [1:0] sz);
      return (sz == 2'd2) ? 2 : (sz == 2'd3) ? 3 : 4;
   endfunction

   // Reference: build the 4x4 matrix as an array, then pack row-major.
   function automatic logic [127:0] model(input int n);
      logic [7:0]   m[4][4];
      logic [127:0] res;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (r < n && c < n) m[r][c] = elems[r*n+c];
            else                m[r][c] = (r == c) ? 8'h01 : 8'h00;
            res[127-8*(4*r+c) -: 8] = m[r][c];
         end
      return res;
   endfunction

   // Monitor: every handshake on the output side is checked against the queue.
   always @(negedge clk) begin
      if (rst_n && mat_valid && mat_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_handoff", 128'd1, 128'd0);
         end else begin
            chk("handoff_mat_out", mat_out, sb.pop_front());
         end
      end
   end

   // abort_after > 0 returns right after that many accepted beats.
   task automatic do_load(input logic [1:0] sz, input int abort_after);
      int n, s_cyc, gap_tot;
      n = dim_of(sz);
      gap_tot = 0;
      @(posedge clk); #1;
      start = 1'b1;
      size  = sz;
      last_exp = model(n);
      sb.push_back(last_exp);
      @(posedge clk); #1;
      start = 1'b0;
      s_cyc = cyc;
      for (int i = 0; i < n*n; i++) begin
         in_valid = 1'b0;
         for (int g = 0; g < gaps[i]; g++) begin
            @(posedge clk); #1;
         end
         gap_tot += gaps[i];
         in_valid = 1'b1;
         in_data  = elems[i];
         @(negedge clk);
         chk("in_ready_load", {127'd0, in_ready}, 128'd1);
         if (i == n*n-1) chk("valid_before_last", {127'd0, mat_valid}, 128'd0);
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (i + 1 == abort_after) return;
      end
      chk("load_cycles", 128'(cyc - s_cyc), 128'(n*n + gap_tot));
      @(negedge clk);
      chk("valid_after_last", {125'd0, mat_valid, busy, in_ready}, 128'b110);
   endtask

   task automatic handoff(input int delay);
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         chk("valid_wait", {127'd0, mat_valid}, 128'd1);
      end
      @(posedge clk); #1;
      mat_ready = 1'b1;
      @(posedge clk); #1;
      mat_ready = 1'b0;
      @(negedge clk);
      chk("after_handoff", {126'd0, mat_valid, busy}, 128'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("reset_outputs", {mat_valid, in_ready, busy, start_err, mat_out[123:0]}, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 4x4 ascending, back-to-back
      for (int i = 0; i < 16; i++) begin elems[i] = 8'(i + 1); gaps[i] = 0; end
      do_load(2'd0, 0);
      chk("mat_4x4_literal", mat_out, 128'h0102030405060708090A0B0C0D0E0F10);

      // Hold 20 cycles with extra beats and a stray start
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         start    = (c == 5);
         in_valid = 1'b1;
         in_data  = 8'hAA;
         @(negedge clk);
         chk("hold_flags", {124'd0, mat_valid, in_ready, busy, start_err},
             {124'd0, 1'b1, 1'b0, 1'b1, (c == 6)});
         chk("hold_mat", mat_out, last_exp);
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      handoff(0);

      // 2x2
      elems[0] = 8'h03; elems[1] = 8'hFE; elems[2] = 8'h05; elems[3] = 8'h07;
      do_load(2'd2, 0);
      chk("mat_2x2_literal", mat_out, 128'h03FE0000050700000000010000000001);
      handoff(2);

      // 3x3 with stalls before beats 3 and 7
      for (int i = 0; i < 16; i++) begin elems[i] = 8'(i + 1); gaps[i] = 0; end
      gaps[2] = 2; gaps[6] = 2;
      do_load(2'd3, 0);
      chk("mat_3x3_pad", {mat_out[103:96], mat_out[71:64], mat_out[39:0]}, 128'h0000_0000000001);
      handoff(1);
      gaps[2] = 0; gaps[6] = 0;

      // Reset mid-load, then all-0x80 4x4
      do_load(2'd0, 7);
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("async_reset", {mat_valid, in_ready, busy, start_err, mat_out[123:0]}, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) elems[i] = 8'h80;
      do_load(2'd0, 0);
      chk("mat_all_80", mat_out, {16{8'h80}});
      handoff(0);

      // start together with mat_ready in HOLD
      for (int i = 0; i < 4; i++) elems[i] = 8'($urandom);
      do_load(2'd2, 0);
      @(posedge clk); #1;
      start = 1'b1; mat_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mat_ready = 1'b0;
      @(negedge clk);
      chk("start_ready_flags", {124'd0, mat_valid, in_ready, busy, start_err}, 128'b0001);
      chk("start_ready_keep", mat_out, last_exp);
      @(negedge clk);
      chk("start_err_once", {126'd0, start_err, busy}, 128'd0);

      // Randomized loads
      for (int t = 0; t < 24; t++) begin
         logic [1:0] sz;
         sz = 2'($urandom_range(0, 3));
         for (int i = 0; i < 16; i++) begin
            elems[i] = 8'($urandom);
            gaps[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         end
         do_load(sz, 0);
         handoff(int'($urandom_range(0, 4)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 128'(sb.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
